// File: rtl/icache_dm.sv
// Direct-mapped, blocking instruction cache serving whole 128-bit lines to the IFQ.
// A miss fetches the line from memory as four 32-bit beats and installs it before lookups resume.
module icache_dm #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  Pc_in,
    input  logic         Rd_en,
    output logic [127:0] Dout,
    output logic         Dout_valid,
    input  logic         Invalidate,
    output logic         Busy,
    output logic [31:0]  Mem_addr,
    output logic         Mem_rd_en,
    input  logic [31:0]  Mem_data,
    input  logic         Mem_data_valid
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [27:0]           base_q, base_d;
    logic [127:0]          fill_buf;
    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [127:0]          data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic                  hit;
    logic                  unused_pc_bits;

    assign idx            = Pc_in[4 +: INDEX_BITS];
    assign pc_tag         = Pc_in[31 -: TAG_W];
    assign fill_idx       = base_q[INDEX_BITS-1:0];
    assign unused_pc_bits = ^Pc_in[3:0];

    // Lookup is only meaningful in IDLE; the cache never hits under a miss.
    assign hit        = valid_q[idx] && (tag_mem[idx] == pc_tag) && (state_q == IDLE);
    assign Dout_valid = Rd_en && hit && !Invalidate && !reset;
    assign Dout       = Dout_valid ? data_mem[idx] : '0;
    assign Busy       = (state_q != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        Mem_rd_en = 1'b0;
        Mem_addr  = '0;
        unique case (state_q)
            IDLE: begin
                if (Rd_en && !hit && !Invalidate) begin
                    base_d  = Pc_in[31:4];
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                Mem_rd_en = 1'b1;
                Mem_addr  = {base_q, beat_q, 2'b00};
                if (Mem_data_valid) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (Invalidate) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            base_q   <= '0;
            valid_q  <= '0;
            fill_buf <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            if (Invalidate)
                valid_q <= '0;
            else if (state_q == WRITE)
                valid_q[fill_idx] <= 1'b1;
            // Beat 0 lands in the most significant word of the line.
            if (state_q == FILL && Mem_data_valid)
                fill_buf[{~beat_q, 5'b00000} +: 32] <= Mem_data;
        end
    end

    // NOTE: tag/data arrays have no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (!reset && !Invalidate && state_q == WRITE) begin
            data_mem[fill_idx] <= fill_buf;
            tag_mem[fill_idx]  <= base_q[27 -: TAG_W];
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios then random traffic, checked
// against a line-level model of the cache contents and a hashed instruction memory.
module tb_icache_dm;
    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  Pc_in;
    logic         Rd_en;
    logic [127:0] Dout;
    logic         Dout_valid;
    logic         Invalidate;
    logic         Busy;
    logic [31:0]  Mem_addr;
    logic         Mem_rd_en;
    logic [31:0]  Mem_data;
    logic         Mem_data_valid;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Model of cache contents: 16 lines, index = (pc/16)%16, tag = pc/256.
    bit           m_valid [16];
    logic [31:0]  m_tag   [16];
    logic [127:0] m_data  [16];

    icache_dm #(.INDEX_BITS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .Pc_in          (Pc_in),
        .Rd_en          (Rd_en),
        .Dout           (Dout),
        .Dout_valid     (Dout_valid),
        .Invalidate     (Invalidate),
        .Busy           (Busy),
        .Mem_addr       (Mem_addr),
        .Mem_rd_en      (Mem_rd_en),
        .Mem_data       (Mem_data),
        .Mem_data_valid (Mem_data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) return 32'hA0 + (a - 32'h100) / 4;
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One IDLE-state cycle: drive a request, compare the same-cycle response, report a miss.
    task automatic lookup(input logic [31:0] pc, input logic rd, input logic inv, output logic miss);
        int   li;
        logic lhit;
        logic exp_dv;
        Pc_in          = pc;
        Rd_en          = rd;
        Invalidate     = inv;
        Mem_data_valid = 1'($urandom_range(0, 1));
        Mem_data       = $urandom;
        #1;
        li     = (pc / 16) % 16;
        lhit   = m_valid[li] && (m_tag[li] == pc / 256);
        exp_dv = rd && lhit && !inv;
        check("idle_busy", 128'(Busy), 128'(0));
        check("idle_mem_rd_en", 128'(Mem_rd_en), 128'(0));
        check("idle_mem_addr", 128'(Mem_addr), 128'(0));
        check("lookup_dout_valid", 128'(Dout_valid), 128'(exp_dv));
        check("lookup_dout", Dout, exp_dv ? m_data[li] : 128'(0));
        miss = rd && !lhit && !inv;
        if (inv) clear_model();
        @(negedge clk);
        Invalidate     = 1'b0;
        Mem_data_valid = 1'b0;
    endtask

    // Memory side of a fill, starting the cycle after the miss was detected.
    // Each beat waits a random wmin..wmax idle cycles; Invalidate or reset may abort at a beat.
    task automatic serve_fill(input logic [31:0] pc_miss, input int wmin, input int wmax,
                              input int inv_beat, input int rst_beat);
        logic [31:0]  base;
        logic [127:0] line;
        int           w;
        int           li;
        base = pc_miss & ~32'hF;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(wmin, wmax);
            for (int c = 0; c <= w; c++) begin
                // Redirect noise on the IFQ side must not disturb the fill.
                Pc_in          = $urandom;
                Rd_en          = 1'($urandom_range(0, 1));
                Mem_data_valid = (c == w);
                Mem_data       = (c == w) ? mem_word(base + 4 * k) : $urandom;
                if (c == w && k == inv_beat) Invalidate = 1'b1;
                if (c == w && k == rst_beat) reset = 1'b1;
                #1;
                check("fill_mem_rd_en", 128'(Mem_rd_en), 128'(1));
                check("fill_mem_addr", 128'(Mem_addr), 128'(base + 4 * k));
                check("fill_busy", 128'(Busy), 128'(1));
                check("fill_dout_valid", 128'(Dout_valid), 128'(0));
                @(negedge clk);
            end
            if (k == inv_beat || k == rst_beat) begin
                Invalidate     = 1'b0;
                reset          = 1'b0;
                Rd_en          = 1'b0;
                Mem_data_valid = 1'b0;
                #1;
                check("abort_busy", 128'(Busy), 128'(0));
                check("abort_mem_rd_en", 128'(Mem_rd_en), 128'(0));
                check("abort_mem_addr", 128'(Mem_addr), 128'(0));
                check("abort_dout_valid", 128'(Dout_valid), 128'(0));
                clear_model();
                return;
            end
            line[(3 - k) * 32 +: 32] = mem_word(base + 4 * k);
        end
        Pc_in          = $urandom;
        Rd_en          = 1'b1;
        Mem_data_valid = 1'($urandom_range(0, 1));
        #1;
        check("write_busy", 128'(Busy), 128'(1));
        check("write_mem_rd_en", 128'(Mem_rd_en), 128'(0));
        check("write_dout_valid", 128'(Dout_valid), 128'(0));
        @(negedge clk);
        Mem_data_valid = 1'b0;
        Rd_en          = 1'b0;
        li             = (base / 16) % 16;
        m_valid[li]    = 1'b1;
        m_tag[li]      = base / 256;
        m_data[li]     = line;
    endtask

    task automatic access(input logic [31:0] pc, input int wmin, input int wmax);
        logic miss;
        lookup(pc, 1'b1, 1'b0, miss);
        if (miss) serve_fill(pc, wmin, wmax, -1, -1);
    endtask

    initial begin
        logic miss;
        reset          = 1'b1;
        Pc_in          = '0;
        Rd_en          = 1'b0;
        Invalidate     = 1'b0;
        Mem_data       = '0;
        Mem_data_valid = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);

        // Reset state, with a live request that must not be answered.
        Rd_en = 1'b1;
        Pc_in = 32'h100;
        #1;
        check("rst_busy", 128'(Busy), 128'(0));
        check("rst_dout_valid", 128'(Dout_valid), 128'(0));
        check("rst_dout", Dout, 128'(0));
        check("rst_mem_rd_en", 128'(Mem_rd_en), 128'(0));
        check("rst_mem_addr", 128'(Mem_addr), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        Rd_en = 1'b0;

        // Cold miss at 0x100 with a zero-wait memory, then same-cycle hit on another offset.
        access(32'h100, 0, 0);
        Pc_in = 32'h10C;
        Rd_en = 1'b1;
        #1;
        check("cold_dout_valid", 128'(Dout_valid), 128'(1));
        check("cold_dout", Dout, 128'h000000A0_000000A1_000000A2_000000A3);
        @(negedge clk);

        // Rd_en low: no response and no fill; then a plain hit.
        lookup(32'h108, 1'b0, 1'b0, miss);
        lookup(32'h104, 1'b1, 1'b0, miss);

        // Two wait states per beat.
        access(32'h480, 2, 2);
        access(32'h48C, 0, 0);

        // Conflict on index 0: 0x200 evicts 0x100 and vice versa.
        access(32'h200, 0, 0);
        access(32'h100, 0, 0);
        access(32'h100, 0, 0);

        // Redirect mid-fill: 0x100 still installed, 0x340 misses afterwards, 0x100 hits.
        lookup(32'h0, 1'b0, 1'b1, miss);
        access(32'h100, 0, 1);
        access(32'h340, 0, 0);
        access(32'h104, 0, 0);

        // Invalidate at beat 2, then 0x100 misses.
        lookup(32'h500, 1'b1, 1'b0, miss);
        if (miss) serve_fill(32'h500, 0, 0, 2, -1);
        access(32'h100, 0, 0);

        // Reset at beat 2, then 0x100 misses again.
        lookup(32'h600, 1'b1, 1'b0, miss);
        if (miss) serve_fill(32'h600, 0, 0, -1, 2);
        access(32'h100, 0, 0);

        // Random traffic over 48 lines (three tags per index) with occasional invalidates.
        for (int n = 0; n < 120; n++) begin
            logic [31:0] pc;
            logic        rd;
            logic        inv;
            pc  = 32'($urandom_range(0, 47)) * 16 + 32'($urandom_range(0, 15));
            rd  = ($urandom_range(0, 3) != 0);
            inv = ($urandom_range(0, 19) == 0);
            lookup(pc, rd, inv, miss);
            if (miss)
                serve_fill(pc, 0, 2, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
